fifo_wptr_full: RTL and testbench

Write-side pointer and status generator for the asynchronous FIFO. It runs entirely in the write clock domain and keeps the binary write address for the dual-port RAM. It produces the Gray-coded write pointer that the read domain samples through its two-flop synchronizer. It also compares its own pointer against the already-synchronized Gray read pointer to produce full, almost-full, occupancy and overflow status.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/gray2bin_conv.sv | 13 +
 rtl/fifo_wptr_full.sv | 76 +++++++
 tb/tb_fifo_wptr_full.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks: Gray/binary conversion and depth derivation.
package fifo_pkg;

  localparam int unsigned MAX_PTR_W = 32;

  function automatic int unsigned depth_of(input int unsigned addrsize);
    return 32'(1) << addrsize;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Only the low 'width' bits of g are meaningful; higher bits are ignored.
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g,
                                                     input int unsigned width);
    logic [MAX_PTR_W-1:0] b;
    b = '0;
    for (int i = int'(width) - 1; i >= 0; i--) begin
      if (i == int'(width) - 1) b[i] = g[i];
      else                      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_conv #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and status block of the async FIFO: binary RAM address, Gray pointer
// for the read-side synchronizer, and pessimistic full/almost-full/occupancy/overflow status.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = 4,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rq2_rptr,
  input  logic                ovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned DEPTH = depth_of(ADDRSIZE);
  localparam int unsigned AFULL_LEVEL = DEPTH - AFULL_MARGIN;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_gray;
  logic [PW-1:0] occ_next;
  logic          full_next;
  logic          afull_next;
  logic          ovf_next;

  gray2bin_conv #(.W(PW)) u_rptr_conv (
    .gray (rq2_rptr),
    .bin  (rbin)
  );

  assign wen = winc & ~wfull;

  // Next-state: the compare uses the post-write pointer so a write and a read-pointer
  // advance in the same cycle are both reflected.
  always_comb begin
    wbin_next  = wbin + PW'(wen);
    wgray_next = PW'(bin2gray(MAX_PTR_W'(wbin_next)));
    full_gray  = {~rq2_rptr[ADDRSIZE:ADDRSIZE-1], rq2_rptr[ADDRSIZE-2:0]};
    full_next  = (wgray_next == full_gray);
    occ_next   = wbin_next - rbin;
    afull_next = (occ_next >= PW'(AFULL_LEVEL));
    ovf_next   = (winc & wfull) | (woverflow & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin         <= '0;
      waddr        <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbin_next;
      waddr        <= wbin_next[ADDRSIZE-1:0];
      wptr         <= wgray_next;
      wfull        <= full_next;
      walmost_full <= afull_next;
      wcount       <= occ_next;
      woverflow    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full (ADDRSIZE=4, AFULL_MARGIN=2): the driver queues expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_fifo_wptr_full;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [4:0] rq2_rptr;
  logic       ovf_clr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       woverflow;

  fifo_wptr_full #(.ADDRSIZE(4), .AFULL_MARGIN(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .rq2_rptr     (rq2_rptr),
    .ovf_clr      (ovf_clr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wcount;
    logic       wovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Bench model state
  logic [4:0] m_bin;
  logic [4:0] m_cnt;
  logic       m_full;
  logic       m_afull;
  logic       m_ovf;

  task automatic chk(input string name, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, id, act, exp);
    end
  endtask

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_bin = '0; m_cnt = '0; m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
  endtask

  // One clock of stimulus; returns at posedge+1 with registered outputs settled.
  task automatic step(input logic i_winc, input logic [4:0] i_rq2, input logic i_clr);
    exp_t e;
    logic e_wen;
    @(negedge clk);
    #1;
    winc = i_winc; rq2_rptr = i_rq2; ovf_clr = i_clr;
    e_wen = i_winc & ~m_full;
    m_ovf = (i_winc & m_full) | (m_ovf & ~i_clr);
    if (e_wen) m_bin = m_bin + 5'd1;
    m_cnt   = m_bin - g2b(i_rq2);
    m_full  = (m_cnt == 5'd16);
    m_afull = (m_cnt >= 5'd14);
    step_id++;
    e.id = step_id; e.wen = i_winc & ~m_full; e.waddr = m_bin[3:0]; e.wptr = b2g(m_bin);
    e.wfull = m_full; e.wafull = m_afull; e.wcount = m_cnt; e.wovf = m_ovf;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 5) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d items left, expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: compares every queued expectation at the negedge after its edge.
  logic [4:0] prev_wptr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_wptr = '0;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      chk("wen",          e.id, int'(wen),          int'(e.wen));
      chk("waddr",        e.id, int'(waddr),        int'(e.waddr));
      chk("wptr",         e.id, int'(wptr),         int'(e.wptr));
      chk("wfull",        e.id, int'(wfull),        int'(e.wfull));
      chk("walmost_full", e.id, int'(walmost_full), int'(e.wafull));
      chk("wcount",       e.id, int'(wcount),       int'(e.wcount));
      chk("woverflow",    e.id, int'(woverflow),    int'(e.wovf));
      if (wptr != prev_wptr)
        chk("wptr_onebit", e.id, $countones(wptr ^ prev_wptr), 1);
      prev_wptr = wptr;
    end
  end

  logic [4:0] gq[$];

  initial begin
    rst = 1'b0; winc = 1'b0; rq2_rptr = '0; ovf_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wptr",   0, int'(wptr),   0);
    chk("rst_wcount", 0, int'(wcount), 0);
    chk("rst_wfull",  0, int'(wfull),  0);
    rst = 1'b1;

    // Fill from empty
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 5'b00000, 1'b0);
      if (i == 13) chk("afull_13", step_id, int'(walmost_full), 0);
      if (i == 14) chk("afull_14", step_id, int'(walmost_full), 1);
    end
    chk("fill_wptr",  step_id, int'(wptr),  int'(5'b11000));
    chk("fill_wfull", step_id, int'(wfull), 1);
    chk("fill_waddr", step_id, int'(waddr), 0);
    chk("fill_cnt",   step_id, int'(wcount), 16);

    // Write while full, then clear, then clear coinciding with a new overflow
    step(1'b1, 5'b00000, 1'b0);
    chk("ovf_set",   step_id, int'(woverflow), 1);
    chk("ovf_wptr",  step_id, int'(wptr), int'(5'b11000));
    step(1'b0, 5'b00000, 1'b1);
    chk("ovf_clr",   step_id, int'(woverflow), 0);
    step(1'b1, 5'b00000, 1'b0);
    step(1'b1, 5'b00000, 1'b1);
    chk("ovf_set_wins", step_id, int'(woverflow), 1);
    step(1'b0, 5'b00000, 1'b1);

    // Release by one read
    step(1'b0, 5'b00001, 1'b0);
    chk("rel_wfull", step_id, int'(wfull), 0);
    chk("rel_cnt",   step_id, int'(wcount), 15);
    chk("rel_afull", step_id, int'(walmost_full), 1);

    // Simultaneous write and read advance at count 15
    step(1'b1, 5'b00011, 1'b0);
    chk("sim_cnt",   step_id, int'(wcount), 15);
    chk("sim_wfull", step_id, int'(wfull), 0);
    drain();

    // Mid-stream asynchronous reset
    #2;
    winc = 1'b1;
    rst = 1'b0;
    #1;
    chk("mrst_wptr",   0, int'(wptr),   0);
    chk("mrst_waddr",  0, int'(waddr),  0);
    chk("mrst_wcount", 0, int'(wcount), 0);
    chk("mrst_afull",  0, int'(walmost_full), 0);
    chk("mrst_ovf",    0, int'(woverflow), 0);
    chk("mrst_wen1",   0, int'(wen), 1);
    winc = 1'b0;
    #1;
    chk("mrst_wen0",   0, int'(wen), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // Wrap with read pointer trailing by three writes
    gq = '{5'b0, 5'b0, 5'b0};
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, gq.pop_front(), 1'b0);
      gq.push_back(b2g(m_bin));
      if (wfull) chk("wrap_nofull", step_id, int'(wfull), 0);
      if (i == 15) chk("wrap_waddr15", step_id, int'(waddr), 15);
      if (i == 16) chk("wrap_waddr0",  step_id, int'(waddr), 0);
      if (i == 31) chk("wrap_wptr31",  step_id, int'(wptr), int'(5'b10000));
      if (i == 32) chk("wrap_wptr0",   step_id, int'(wptr), 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
